exc_ctrl: RTL and testbench

Parametrised exception/interrupt controller for the MIPS core. It replaces the single-cycle combinational exception decode with a registered, multi-source controller. The controller latches edge-triggered interrupt requests, prioritises them against syscall and ERET at the commit point, and captures EPC and cause. It then sequences a multi-cycle pipeline flush, followed by a single-cycle PC redirect to a computed handler vector or back to EPC.

---
 rtl/exc_ctrl.sv | 160 ++++++++++++++++
 tb/tb_exc_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Registered exception/IRQ controller: edge-latched IRQs, ERET > syscall > IRQ at commit.
// Accept-to-redirect latency FLUSH_CYCLES+1; commit inputs ignored while a flush/redirect is in flight.
module exc_ctrl #(
  parameter int               WIDTH        = 32,
  parameter int               NUM_IRQ      = 4,
  parameter int               FLUSH_CYCLES = 2,
  parameter logic [WIDTH-1:0] VEC_BASE     = 32'h0000_0100,
  parameter logic [WIDTH-1:0] VEC_STRIDE   = 32'h0000_0020
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               syscall_i,
  input  logic               eret_i,
  input  logic               commit_valid_i,
  input  logic [WIDTH-1:0]   commit_pc_i,
  input  logic               mask_we_i,
  input  logic [NUM_IRQ-1:0] mask_wdata_i,
  output logic               flush_o,
  output logic               redirect_o,
  output logic [WIDTH-1:0]   redirect_pc_o,
  output logic [WIDTH-1:0]   epc_o,
  output logic [7:0]         cause_o,
  output logic               in_handler_o,
  output logic [NUM_IRQ-1:0] pending_o
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [WIDTH-1:0]   epc_q, epc_d;
  logic [WIDTH-1:0]   tgt_q, tgt_d;
  logic [7:0]         cause_q, cause_d;
  logic               exl_q, exl_d;
  logic               exl_tgt_q, exl_tgt_d;
  logic               flush_q, redir_q;

  logic               irq_hit;
  logic [NUM_IRQ-1:0] irq_sel;
  logic [7:0]         irq_cause;
  logic [WIDTH-1:0]   irq_vec;
  logic               idle, take_eret, take_sys, take_irq;

  // Scan from the top down so the lowest enabled pending index wins.
  always_comb begin
    irq_hit   = 1'b0;
    irq_sel   = '0;
    irq_cause = '0;
    irq_vec   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_q[i] && mask_q[i]) begin
        irq_hit    = 1'b1;
        irq_sel    = '0;
        irq_sel[i] = 1'b1;
        irq_cause  = 8'(i + 1);
        irq_vec    = VEC_BASE + VEC_STRIDE * WIDTH'(i + 1);
      end
    end
  end

  assign idle      = (state_q == S_IDLE);
  assign take_eret = idle & commit_valid_i & eret_i & exl_q;
  assign take_sys  = idle & commit_valid_i & syscall_i & ~take_eret;
  assign take_irq  = idle & commit_valid_i & ~exl_q & ~syscall_i & irq_hit;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    epc_d     = epc_q;
    tgt_d     = tgt_q;
    cause_d   = cause_q;
    exl_d     = exl_q;
    exl_tgt_d = exl_tgt_q;
    mask_d    = mask_we_i ? mask_wdata_i : mask_q;
    pending_d = (pending_q & ~({NUM_IRQ{take_irq}} & irq_sel)) | (irq_i & ~irq_prev_q);

    case (state_q)
      S_IDLE: begin
        if (take_eret || take_sys || take_irq) begin
          state_d = S_FLUSH;
          cnt_d   = CW'(FLUSH_CYCLES);
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_REDIR;
          exl_d   = exl_tgt_q;
        end
      end
      S_REDIR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (take_eret) begin
      tgt_d     = epc_q;
      exl_tgt_d = 1'b0;
    end
    // A nested syscall keeps the outer return address.
    if (take_sys) begin
      tgt_d     = VEC_BASE;
      cause_d   = '0;
      exl_tgt_d = 1'b1;
      if (!exl_q) epc_d = commit_pc_i + WIDTH'(4);
    end
    if (take_irq) begin
      tgt_d     = irq_vec;
      cause_d   = irq_cause;
      epc_d     = commit_pc_i;
      exl_tgt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '1;
      epc_q      <= '0;
      tgt_q      <= '0;
      cause_q    <= '0;
      exl_q      <= 1'b0;
      exl_tgt_q  <= 1'b0;
      flush_q    <= 1'b0;
      redir_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      irq_prev_q <= irq_i;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      epc_q      <= epc_d;
      tgt_q      <= tgt_d;
      cause_q    <= cause_d;
      exl_q      <= exl_d;
      exl_tgt_q  <= exl_tgt_d;
      flush_q    <= (state_d == S_FLUSH);
      redir_q    <= (state_d == S_REDIR);
    end
  end

  assign flush_o       = flush_q;
  assign redirect_o    = redir_q;
  assign redirect_pc_o = tgt_q;
  assign epc_o         = epc_q;
  assign cause_o       = cause_q;
  assign in_handler_o  = exl_q;
  assign pending_o     = pending_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: per-cycle comparison against a phase-counting model plus literal pins.
module tb_exc_ctrl;
  localparam int          F  = 2;
  localparam logic [31:0] VB = 32'h0000_0100;
  localparam logic [31:0] VS = 32'h0000_0020;

  logic        clk, rst_n;
  logic [3:0]  irq_i;
  logic        syscall_i, eret_i, commit_valid_i, mask_we_i;
  logic [31:0] commit_pc_i;
  logic [3:0]  mask_wdata_i;
  logic        flush_o, redirect_o, in_handler_o;
  logic [31:0] redirect_pc_o, epc_o;
  logic [7:0]  cause_o;
  logic [3:0]  pending_o;

  int n_vec = 0;
  int n_err = 0;
  int n_flush = 0;
  int n_redir = 0;

  exc_ctrl #(.WIDTH(32), .NUM_IRQ(4), .FLUSH_CYCLES(F), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .syscall_i(syscall_i), .eret_i(eret_i),
    .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i), .mask_we_i(mask_we_i),
    .mask_wdata_i(mask_wdata_i), .flush_o(flush_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .epc_o(epc_o), .cause_o(cause_o),
    .in_handler_o(in_handler_o), .pending_o(pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // t counts cycles since the accepting edge (-1 when no exception is in flight).
  typedef struct packed {
    logic [3:0]  pend;
    logic [3:0]  mask;
    logic [3:0]  prev;
    logic [31:0] epc;
    logic [31:0] tgt;
    logic [7:0]  cause;
    logic        exl;
    logic        exl_after;
    int          t;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r = '0;
    r.mask = 4'hF;
    r.t = -1;
    return r;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t s, input logic [3:0] irq, input logic cv,
                                    input logic sys, input logic er, input logic [31:0] pc,
                                    input logic mwe, input logic [3:0] mw);
    mdl_t n;
    int   win;
    bit   acc;
    n = s;
    win = -1;
    acc = 1'b0;
    if (s.t < 0 && cv) begin
      if (er && s.exl) begin
        acc = 1'b1; n.tgt = s.epc; n.exl_after = 1'b0;
      end else if (sys) begin
        acc = 1'b1; n.tgt = VB; n.cause = 8'd0; n.exl_after = 1'b1;
        if (!s.exl) n.epc = pc + 32'd4;
      end else if (!s.exl) begin
        for (int i = 3; i >= 0; i--) if (s.pend[i] && s.mask[i]) win = i;
        if (win >= 0) begin
          acc = 1'b1; n.cause = 8'(win + 1); n.tgt = VB + 32'(win + 1) * VS;
          n.epc = pc; n.exl_after = 1'b1; n.pend[win] = 1'b0;
        end
      end
    end
    if (acc) n.t = 1;
    else if (s.t >= 1) begin
      n.t = s.t + 1;
      if (n.t == F + 1) n.exl = s.exl_after;
      if (n.t > F + 1) n.t = -1;
    end
    n.pend = n.pend | (irq & ~s.prev);
    if (mwe) n.mask = mw;
    n.prev = irq;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= mdl_reset();
    else m <= mdl_next(m, irq_i, commit_valid_i, syscall_i, eret_i, commit_pc_i, mask_we_i, mask_wdata_i);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (flush_o) n_flush++;
    if (redirect_o) n_redir++;
    check("mdl_flush", 32'(flush_o), 32'(m.t >= 1 && m.t <= F));
    check("mdl_redirect", 32'(redirect_o), 32'(m.t == F + 1));
    if (m.t == F + 1) check("mdl_redirect_pc", redirect_pc_o, m.tgt);
    check("mdl_epc", epc_o, m.epc);
    check("mdl_cause", 32'(cause_o), 32'(m.cause));
    check("mdl_in_handler", 32'(in_handler_o), 32'(m.exl));
    check("mdl_pending", 32'(pending_o), 32'(m.pend));
  end

  task automatic commit(input logic [31:0] pc, input logic sys, input logic er);
    @(posedge clk); #1;
    commit_valid_i = 1'b1; commit_pc_i = pc; syscall_i = sys; eret_i = er;
    @(posedge clk); #1;
    commit_valid_i = 1'b0; syscall_i = 1'b0; eret_i = 1'b0;
  endtask

  task automatic wait_redirect(input string nm);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (redirect_o) found = 1'b1;
    end
    if (!found) begin
      n_vec++; n_err++;
      $display("FAIL %s: no redirect within 12 cycles, expected one", nm);
    end
  endtask

  task automatic write_mask(input logic [3:0] v);
    @(posedge clk); #1;
    mask_we_i = 1'b1; mask_wdata_i = v;
    @(posedge clk); #1;
    mask_we_i = 1'b0;
  endtask

  int f0, r0;

  initial begin
    rst_n = 1'b0; irq_i = '0; syscall_i = 1'b0; eret_i = 1'b0; commit_valid_i = 1'b0;
    commit_pc_i = '0; mask_we_i = 1'b0; mask_wdata_i = '0;
    repeat (3) @(negedge clk);
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_redirect", 32'(redirect_o), 32'd0);
    check("rst_redirect_pc", redirect_pc_o, 32'd0);
    check("rst_epc", epc_o, 32'd0);
    check("rst_cause", 32'(cause_o), 32'd0);
    check("rst_in_handler", 32'(in_handler_o), 32'd0);
    check("rst_pending", 32'(pending_o), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // IRQ0 edge: pending one cycle later, then taken at commit of 0x400.
    @(posedge clk); #1; irq_i = 4'b0001;
    @(negedge clk); check("irq0_pend_same_cycle", 32'(pending_o), 32'h0);
    @(negedge clk); check("irq0_pend_next_cycle", 32'(pending_o), 32'h1);
    f0 = n_flush;
    commit(32'h400, 1'b0, 1'b0);
    wait_redirect("irq0_redirect");
    check("irq0_flush_cycles", 32'(n_flush - f0), 32'd2);
    check("irq0_target", redirect_pc_o, 32'h120);
    check("irq0_cause", 32'(cause_o), 32'd1);
    check("irq0_epc", epc_o, 32'h400);
    check("irq0_in_handler", 32'(in_handler_o), 32'd1);
    check("irq0_pend_cleared", 32'(pending_o), 32'h0);
    irq_i = 4'b0000;
    commit(32'h1234, 1'b0, 1'b1);
    wait_redirect("eret0_redirect");
    check("eret0_target", redirect_pc_o, 32'h400);
    check("eret0_in_handler", 32'(in_handler_o), 32'd0);

    // Syscall beats pending IRQ2.
    irq_i = 4'b0100;
    commit(32'h500, 1'b1, 1'b0);
    wait_redirect("sys_redirect");
    check("sys_target", redirect_pc_o, 32'h100);
    check("sys_cause", 32'(cause_o), 32'd0);
    check("sys_epc", epc_o, 32'h504);
    check("sys_pend_kept", 32'(pending_o), 32'h4);
    check("sys_in_handler", 32'(in_handler_o), 32'd1);

    // Nested syscall inside the handler keeps EPC; IRQ3 edge latches only.
    irq_i = 4'b1100;
    commit(32'h600, 1'b1, 1'b0);
    wait_redirect("nested_redirect");
    check("nested_target", redirect_pc_o, 32'h100);
    check("nested_epc", epc_o, 32'h504);
    check("nested_pending", 32'(pending_o), 32'hC);
    f0 = n_flush;
    commit(32'h700, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("handler_blocks_irq", 32'(n_flush - f0), 32'd0);
    commit(32'h0, 1'b0, 1'b1);
    wait_redirect("eret1_redirect");
    check("eret1_target", redirect_pc_o, 32'h504);
    check("eret1_in_handler", 32'(in_handler_o), 32'd0);
    commit(32'h800, 1'b0, 1'b0);
    wait_redirect("irq2_redirect");
    check("irq2_target", redirect_pc_o, 32'h160);
    check("irq2_cause", 32'(cause_o), 32'd3);
    check("irq2_epc", epc_o, 32'h800);
    check("irq2_pending", 32'(pending_o), 32'h8);
    commit(32'h0, 1'b0, 1'b1);
    wait_redirect("eret2_redirect");
    check("eret2_target", redirect_pc_o, 32'h800);

    // Mask 0101 hides IRQ1 and IRQ3; reopening it takes IRQ1.
    irq_i = 4'b0000;
    write_mask(4'b0101);
    irq_i = 4'b0010;
    f0 = n_flush;
    commit(32'h880, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    check("masked_no_take", 32'(n_flush - f0), 32'd0);
    check("masked_pending", 32'(pending_o), 32'hA);
    write_mask(4'b1111);
    commit(32'h900, 1'b0, 1'b0);
    wait_redirect("irq1_redirect");
    check("irq1_target", redirect_pc_o, 32'h140);
    check("irq1_cause", 32'(cause_o), 32'd2);
    check("irq1_pending", 32'(pending_o), 32'h8);
    commit(32'h0, 1'b0, 1'b1);
    wait_redirect("eret3_redirect");

    // Reset during the second flush cycle of a nested syscall.
    irq_i = 4'b0000;
    commit(32'h980, 1'b1, 1'b0);
    wait_redirect("sys2_redirect");
    check("sys2_epc", epc_o, 32'h984);
    commit(32'h990, 1'b1, 1'b0);
    @(posedge clk); #2;
    check("pre_rst_flush", 32'(flush_o), 32'd1);
    rst_n = 1'b0; #1;
    check("midrst_flush", 32'(flush_o), 32'd0);
    check("midrst_redirect", 32'(redirect_o), 32'd0);
    check("midrst_in_handler", 32'(in_handler_o), 32'd0);
    check("midrst_epc", epc_o, 32'd0);
    check("midrst_pending", 32'(pending_o), 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    r0 = n_redir;
    repeat (8) @(negedge clk);
    check("post_rst_no_redirect", 32'(n_redir - r0), 32'd0);

    // ERET outside a handler is ignored.
    f0 = n_flush; r0 = n_redir;
    commit(32'hA00, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("eret_idle_flush", 32'(n_flush - f0), 32'd0);
    check("eret_idle_redirect", 32'(n_redir - r0), 32'd0);

    // Syscall during FLUSH is ignored; an IRQ edge then still latches.
    f0 = n_flush; r0 = n_redir;
    commit(32'hB00, 1'b1, 1'b0);
    commit_valid_i = 1'b1; syscall_i = 1'b1; commit_pc_i = 32'hC00; irq_i = 4'b0001;
    @(posedge clk); #1;
    commit_valid_i = 1'b0; syscall_i = 1'b0;
    repeat (8) @(negedge clk);
    check("flushsys_flush_cycles", 32'(n_flush - f0), 32'd2);
    check("flushsys_redirects", 32'(n_redir - r0), 32'd1);
    check("flushsys_epc", epc_o, 32'hB04);
    check("flushsys_pending", 32'(pending_o), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
